// File: rtl/lieat_wbu_pkg.sv
// ============================================================================
// Module : lieat_wbu_pkg
// Brief  : Shared lieat definitions: writeback source indices and the
//          dispatch op one-hot encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX
`define REG_IDX 5
`endif

package lieat_wbu_pkg;

    localparam int NUM_SRC = 5;
    localparam int COM     = 0;
    localparam int LSU     = 1;
    localparam int MULDIV  = 2;
    localparam int VPU     = 3;
    localparam int FPU     = 4;

    // Dispatch op encoding; wbck_op reuses the same bit order.
    typedef enum logic [NUM_SRC-1:0] {
        OP_NONE   = 5'b00000,
        OP_COM    = 5'b00001,
        OP_LSU    = 5'b00010,
        OP_MULDIV = 5'b00100,
        OP_VPU    = 5'b01000,
        OP_FPU    = 5'b10000
    } lieat_op_e;

    function automatic logic [2:0] rr_next(input logic [2:0] idx, input logic [2:0] last);
        return (idx == last) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lieat_wbu_rrarb.sv
// ============================================================================
// Module : lieat_wbu_rrarb
// Brief  : Combinational round-robin picker: first request at or after ptr,
//          wrapping modulo NUM_SRC; one-hot grant.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lieat_wbu_rrarb
    import lieat_wbu_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic [NUM_SRC-1:0] gnt_o
);

    logic       w_found;
    logic [3:0] w_sum;
    logic [2:0] w_idx;

    always_comb begin
        gnt_o   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_sum = {1'b0, ptr_i} + 4'(k);
            w_idx = (w_sum >= 4'(NUM_SRC)) ? 3'(w_sum - 4'(NUM_SRC)) : w_sum[2:0];
            if (!w_found && req_i[w_idx]) begin
                gnt_o[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lieat_wbu.sv
// ============================================================================
// Module : lieat_wbu
// Brief  : Writeback unit: round-robin arbitration of five result sources into
//          one registered register-file write / retire port.
//          Define LIEAT_WBU_FPU_EN to include fpu in the rotation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lieat_wbu
    import lieat_wbu_pkg::*;
#(
    parameter int XLEN    = `XLEN,
    parameter int REG_IDX = `REG_IDX
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               com_wb_valid,
    output logic               com_wb_ready,
    input  logic [REG_IDX-1:0] com_wb_rd,
    input  logic               com_wb_rdwen,
    input  logic [XLEN-1:0]    com_wb_data,

    input  logic               lsu_wb_valid,
    output logic               lsu_wb_ready,
    input  logic [REG_IDX-1:0] lsu_wb_rd,
    input  logic               lsu_wb_rdwen,
    input  logic [XLEN-1:0]    lsu_wb_data,

    input  logic               muldiv_wb_valid,
    output logic               muldiv_wb_ready,
    input  logic [REG_IDX-1:0] muldiv_wb_rd,
    input  logic               muldiv_wb_rdwen,
    input  logic [XLEN-1:0]    muldiv_wb_data,

    input  logic               vpu_wb_valid,
    output logic               vpu_wb_ready,
    input  logic [REG_IDX-1:0] vpu_wb_rd,
    input  logic               vpu_wb_rdwen,
    input  logic [XLEN-1:0]    vpu_wb_data,

    input  logic               fpu_wb_valid,
    output logic               fpu_wb_ready,
    input  logic [REG_IDX-1:0] fpu_wb_rd,
    input  logic               fpu_wb_rdwen,
    input  logic [XLEN-1:0]    fpu_wb_data,

    output logic               rf_wen,
    output logic [REG_IDX-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               wbck_valid,
    output logic [NUM_SRC-1:0] wbck_op
);

`ifdef LIEAT_WBU_FPU_EN
    localparam logic       FPU_EN   = 1'b1;
    localparam logic [2:0] LAST_SRC = 3'(FPU);
`else
    localparam logic       FPU_EN   = 1'b0;
    localparam logic [2:0] LAST_SRC = 3'(VPU);
`endif

    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_gnt;
    logic [REG_IDX-1:0] w_rd    [NUM_SRC];
    logic [XLEN-1:0]    w_data  [NUM_SRC];
    logic [NUM_SRC-1:0] w_rdwen;

    logic [2:0]         w_sel_idx;
    logic [REG_IDX-1:0] w_sel_rd;
    logic [XLEN-1:0]    w_sel_data;
    logic               w_sel_rdwen;
    logic               w_xfer;
    logic               w_wen;

    logic [2:0]         ptr_q, ptr_d;
    logic               wbck_valid_q;
    logic [NUM_SRC-1:0] wbck_op_q;
    logic               rf_wen_q;
    logic [REG_IDX-1:0] rf_waddr_q;
    logic [XLEN-1:0]    rf_wdata_q;

    // fpu inputs stay wired in; its request is masked off when the unit is absent.
    assign w_req = {fpu_wb_valid & FPU_EN, vpu_wb_valid, muldiv_wb_valid,
                    lsu_wb_valid, com_wb_valid};
    assign w_rdwen = {fpu_wb_rdwen, vpu_wb_rdwen, muldiv_wb_rdwen,
                      lsu_wb_rdwen, com_wb_rdwen};

    assign w_rd[COM]    = com_wb_rd;
    assign w_rd[LSU]    = lsu_wb_rd;
    assign w_rd[MULDIV] = muldiv_wb_rd;
    assign w_rd[VPU]    = vpu_wb_rd;
    assign w_rd[FPU]    = fpu_wb_rd;

    assign w_data[COM]    = com_wb_data;
    assign w_data[LSU]    = lsu_wb_data;
    assign w_data[MULDIV] = muldiv_wb_data;
    assign w_data[VPU]    = vpu_wb_data;
    assign w_data[FPU]    = fpu_wb_data;

    lieat_wbu_rrarb u_rrarb (
        .req_i (w_req),
        .ptr_i (ptr_q),
        .gnt_o (w_gnt)
    );

    assign com_wb_ready    = w_gnt[COM];
    assign lsu_wb_ready    = w_gnt[LSU];
    assign muldiv_wb_ready = w_gnt[MULDIV];
    assign vpu_wb_ready    = w_gnt[VPU];
    assign fpu_wb_ready    = w_gnt[FPU] & FPU_EN;

    always_comb begin
        w_sel_idx   = '0;
        w_sel_rd    = '0;
        w_sel_data  = '0;
        w_sel_rdwen = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_gnt[i]) begin
                w_sel_idx   = 3'(i);
                w_sel_rd    = w_rd[i];
                w_sel_data  = w_data[i];
                w_sel_rdwen = w_rdwen[i];
            end
        end
    end

    assign w_xfer = |w_gnt;
    assign w_wen  = w_xfer & w_sel_rdwen & (w_sel_rd != '0);
    assign ptr_d  = w_xfer ? rr_next(w_sel_idx, LAST_SRC) : ptr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            wbck_valid_q <= 1'b0;
            wbck_op_q    <= '0;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            wbck_valid_q <= w_xfer;
            wbck_op_q    <= w_gnt;
            rf_wen_q     <= w_wen;
            // Address/data only move on an actual register write.
            if (w_wen) begin
                rf_waddr_q <= w_sel_rd;
                rf_wdata_q <= w_sel_data;
            end
        end
    end

    assign wbck_valid = wbck_valid_q;
    assign wbck_op    = wbck_op_q;
    assign rf_wen     = rf_wen_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_lieat_wbu.sv
// ============================================================================
// Module : tb_lieat_wbu
// Brief  : Self-checking bench for lieat_wbu against a round-robin queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lieat_wbu;

`ifdef LIEAT_WBU_FPU_EN
    localparam int NS = 5;
`else
    localparam int NS = 4;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  valid_t;
    logic [4:0]  rd_t    [5];
    logic [31:0] data_t  [5];
    logic        rdwen_t [5];

    logic        com_wb_ready, lsu_wb_ready, muldiv_wb_ready, vpu_wb_ready, fpu_wb_ready;
    logic        rf_wen, wbck_valid;
    logic [4:0]  rf_waddr, wbck_op;
    logic [31:0] rf_wdata;
    wire  [4:0]  rdy_vec = {fpu_wb_ready, vpu_wb_ready, muldiv_wb_ready, lsu_wb_ready, com_wb_ready};

    always #5 clock = ~clock;

    lieat_wbu dut (
        .clock(clock), .reset(reset),
        .com_wb_valid(valid_t[0]), .com_wb_ready(com_wb_ready), .com_wb_rd(rd_t[0]),
        .com_wb_rdwen(rdwen_t[0]), .com_wb_data(data_t[0]),
        .lsu_wb_valid(valid_t[1]), .lsu_wb_ready(lsu_wb_ready), .lsu_wb_rd(rd_t[1]),
        .lsu_wb_rdwen(rdwen_t[1]), .lsu_wb_data(data_t[1]),
        .muldiv_wb_valid(valid_t[2]), .muldiv_wb_ready(muldiv_wb_ready), .muldiv_wb_rd(rd_t[2]),
        .muldiv_wb_rdwen(rdwen_t[2]), .muldiv_wb_data(data_t[2]),
        .vpu_wb_valid(valid_t[3]), .vpu_wb_ready(vpu_wb_ready), .vpu_wb_rd(rd_t[3]),
        .vpu_wb_rdwen(rdwen_t[3]), .vpu_wb_data(data_t[3]),
        .fpu_wb_valid(valid_t[4]), .fpu_wb_ready(fpu_wb_ready), .fpu_wb_rd(rd_t[4]),
        .fpu_wb_rdwen(rdwen_t[4]), .fpu_wb_data(data_t[4]),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wbck_valid(wbck_valid), .wbck_op(wbck_op)
    );

    int          ncmp = 0;
    int          nfail = 0;
    int          mptr;
    int          lastg;
    int          gcnt [5];
    logic        e_valid, e_wen;
    logic [4:0]  e_op, e_waddr;
    logic [31:0] e_wdata;
    logic [4:0]  pend;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [4:0] v);
        for (int k = 0; k < NS; k++) begin
            if (v[(mptr + k) % NS]) return (mptr + k) % NS;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mptr = 0; e_valid = 0; e_wen = 0; e_op = 0; e_waddr = 0; e_wdata = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".wbck_valid"}, 64'(wbck_valid), 64'(e_valid));
        chk({tag, ".wbck_op"},    64'(wbck_op),    64'(e_op));
        chk({tag, ".rf_wen"},     64'(rf_wen),     64'(e_wen));
        chk({tag, ".rf_waddr"},   64'(rf_waddr),   64'(e_waddr));
        chk({tag, ".rf_wdata"},   64'(rf_wdata),   64'(e_wdata));
    endtask

    // Starts at posedge+1: drive, check ready, clock, check registered outputs.
    task automatic step(input string tag, input logic [4:0] v);
        int g;
        logic [4:0] er;
        valid_t = v;
        #1;
        g = model_pick(v);
        er = (g >= 0) ? 5'(1 << g) : 5'd0;
        chk({tag, ".ready"}, 64'(rdy_vec), 64'(er));
        lastg = g;
        e_valid = (g >= 0);
        e_op = er;
        e_wen = (g >= 0) && rdwen_t[g] && (rd_t[g] != 0);
        if (e_wen) begin
            e_waddr = rd_t[g];
            e_wdata = data_t[g];
        end
        if (g >= 0) begin
            mptr = (g + 1) % NS;
            gcnt[g]++;
        end
        @(posedge clock); #1;
        chk_outputs(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1; valid_t = '0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        chk_outputs("reset");
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            rd_t[i] = 5'(i + 1); data_t[i] = 32'(i * 16'h1111); rdwen_t[i] = 1'b1; gcnt[i] = 0;
        end
        do_reset();

        // Single lsu request
        rd_t[1] = 5'd5; data_t[1] = 32'h1234; rdwen_t[1] = 1'b1;
        step("lsu_single", 5'b00010);
        chk("lsu_single.op_literal", 64'(wbck_op), 64'h02);
        chk("lsu_single.waddr_literal", 64'(rf_waddr), 64'd5);
        step("idle", 5'b00000);

        // All sources valid for 10 cycles from ptr=0
        do_reset();
        for (int i = 0; i < 5; i++) gcnt[i] = 0;
        for (int c = 0; c < 10; c++) step("all_valid", 5'b11111);
        for (int i = 0; i < 5; i++)
            chk($sformatf("all_valid.count%0d", i), 64'(gcnt[i]),
                64'((i < NS) ? (10 / NS + ((i < 10 % NS) ? 1 : 0)) : 0));

        // x0 destination and rdwen=0 still retire without writing
        rd_t[2] = 5'd0; rdwen_t[2] = 1'b1; rd_t[3] = 5'd9; rdwen_t[3] = 1'b0;
        do_reset();
        step("mul_x0", 5'b01100);
        chk("mul_x0.op_literal", 64'(wbck_op), 64'h04);
        step("vpu_nowen", 5'b01000);
        chk("vpu_nowen.op_literal", 64'(wbck_op), 64'h08);
        step("idle", 5'b00000);

        // Async reset with output stage full and com pending
        rd_t[0] = 5'd7; data_t[0] = 32'hCAFE_0001; rdwen_t[0] = 1'b1;
        step("pre_reset", 5'b00001);
        step("pre_reset2", 5'b00011);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_outputs("async_reset");
        @(posedge clock); #1;
        chk_outputs("in_reset");
        reset = 1'b0;
        step("post_reset", 5'b00011);
        chk("post_reset.com_first", 64'(lastg), 64'd0);

`ifndef LIEAT_WBU_FPU_EN
        // fpu never participates; vpu wraps straight back to com
        for (int c = 0; c < 20; c++) begin
            step("no_fpu", (c % 2 == 0) ? 5'b11000 : 5'b10001);
            chk("no_fpu.ready", 64'(fpu_wb_ready), 64'd0);
            chk("no_fpu.op4", 64'(wbck_op[4]), 64'd0);
        end
        step("vpu_then", 5'b11000);
        step("then_com", 5'b10001);
        chk("vpu_then_com", 64'(lastg), 64'd0);
`endif

        // Randomized traffic, requests held until granted
        pend = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 5; i++) begin
                if (!pend[i] && ($urandom % 2 == 1)) begin
                    pend[i]    = 1'b1;
                    rd_t[i]    = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
                    data_t[i]  = $urandom;
                    rdwen_t[i] = ($urandom % 4 != 0);
                end
            end
            step("random", pend);
            if (lastg >= 0) pend[lastg] = 1'b0;
        end
        step("drain", 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lieat_wbu.md
LIEAT_WBU -- requirements
Module: lieat_wbu

Interface
REQ-001 The block SHALL take parameter XLEN, default `XLEN (32), datapath width.
REQ-002 The block SHALL take parameter REG_IDX, default `REG_IDX (5), register index width.
REQ-003 The block SHALL have port clock, input, 1, single clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have, for each S in {com, lsu, muldiv, vpu, fpu}:
- S_wb_valid, input, 1, writeback request.
- S_wb_ready, output, 1, grant/accept.
- S_wb_rd, input, REG_IDX, destination register.
- S_wb_rdwen, input, 1, register write required.
- S_wb_data, input, XLEN, result.
REQ-006 The block SHALL have port rf_wen, output, 1, register-file write enable.
REQ-007 The block SHALL have port rf_waddr, output, REG_IDX, register-file write address.
REQ-008 The block SHALL have port rf_wdata, output, XLEN, register-file write data.
REQ-009 The block SHALL have port wbck_valid, output, 1, retire pulse to the decode dependency tracker.
REQ-010 The block SHALL have port wbck_op, output, 5, one-hot source of the retiring op, same bit order as the dispatch op: [0]com [1]lsu [2]muldiv [3]vpu [4]fpu.

Function
REQ-011 Arbitration SHALL be round-robin over the five sources, with a 3-bit priority pointer ptr (0..4).
REQ-012 At most one source SHALL be granted per cycle: the first valid source at or after ptr, wrapping 4->0.
REQ-013 S_wb_ready SHALL be combinational, asserted only for the granted source; a transfer completes when S_wb_valid & S_wb_ready.
REQ-014 After a transfer from source i, ptr SHALL become (i+1) mod 5; with no transfer, ptr SHALL hold.
REQ-015 The granted request SHALL be captured into a single output register stage, giving exactly 1-cycle latency from transfer to rf_*/wbck_* outputs.
REQ-016 wbck_valid SHALL pulse for exactly one cycle per transfer, with wbck_op one-hot for the granted source; otherwise wbck_op SHALL be 0.
REQ-017 rf_wen SHALL equal wbck_valid & registered rdwen & (registered rd != 0).
- Transfers with rdwen=0 or rd=x0 still produce wbck_valid, so the tracker entry retires.
REQ-018 When rf_wen=0, rf_waddr and rf_wdata SHALL hold their previous values.
REQ-019 The output stage SHALL never stall; back-to-back transfers SHALL produce consecutive wbck_valid pulses.
REQ-020 Sources SHALL hold valid and payload stable until ready; the block SHALL NOT drop or duplicate requests.
REQ-021 The block SHALL NOT act on flushes: ops reaching writeback are committed, and flush retirement is handled upstream.

Reset
REQ-022 On reset assertion, the following SHALL asynchronously become 0: ptr, wbck_valid, wbck_op, rf_wen, rf_waddr, rf_wdata.
REQ-023 A request pending at reset SHALL NOT be captured; after deassertion, arbitration SHALL restart from ptr=0 (com).

Configuration
REQ-024 With macro LIEAT_WBU_FPU_EN defined, fpu SHALL participate in arbitration per REQ-011..014.
REQ-025 Without LIEAT_WBU_FPU_EN:
- fpu_wb_ready SHALL be tied 0 and wbck_op[4] SHALL be constant 0.
- The rotation SHALL skip fpu: after a vpu transfer, ptr returns to 0.
- fpu ports SHALL remain present.

Structure
REQ-026 The source index constants (COM=0 .. FPU=4) and NUM_SRC=5 SHALL live in the shared lieat definitions package/header, alongside the dispatch op encoding.
REQ-027 The round-robin picker SHALL be one sub-module, lieat_wbu_rrarb (request vector + ptr in, one-hot grant out, purely combinational); state SHALL remain in lieat_wbu.

Verification
REQ-028 Reset, then single lsu request rd=5, data=0x1234, rdwen=1 -> lsu_wb_ready same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, wbck_op=5'b00010.
REQ-029 All five valid continuously for 10 cycles from ptr=0 -> grant order com, lsu, muldiv, vpu, fpu, com, ...; 10 consecutive wbck_valid pulses, each source granted exactly twice.
REQ-030 muldiv request rd=0, rdwen=1 and vpu request rdwen=0 -> wbck_valid pulses with op 5'b00100 then 5'b01000; rf_wen stays 0 both times.
REQ-031 Reset asserted mid-cycle while com pending and the output stage full -> outputs 0 immediately without waiting for a clock; after release, com granted first.
REQ-032 Build without LIEAT_WBU_FPU_EN, fpu_wb_valid=1 for 20 cycles with vpu/com toggling -> fpu_wb_ready never 1, wbck_op[4] never 1, vpu transfer followed by com grant.
